// File: rtl/hazard_ctrl_unit.sv
// Hazard controller for the RV32IM 5-stage pipeline: load-use stalls, taken-branch
// flushes, multi-cycle MUL/DIV occupancy of EX and a stall-cycle performance counter.
module hazard_ctrl_unit #(
    parameter int REG_AW     = 5,
    parameter int MUL_CYCLES = 3,
    parameter int DIV_CYCLES = 33,
    parameter int PERF_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs1_id,
    input  logic [REG_AW-1:0] rs2_id,
    input  logic              rs1_used_id,
    input  logic              rs2_used_id,
    input  logic [REG_AW-1:0] rd_ex,
    input  logic              mem_read_ex,
    input  logic              branch_taken_ex,
    input  logic              md_op_ex,
    input  logic              md_is_div_ex,
    output logic              pc_stall,
    output logic              if_id_stall,
    output logic              if_id_flush,
    output logic              id_ex_bubble,
    output logic              id_ex_stall,
    output logic              ex_stall,
    output logic              md_busy,
    output logic              md_done,
    output logic [PERF_W-1:0] stall_cycles
);

    localparam int MAX_LAT = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);
    localparam logic [CNT_W-1:0] MUL_LAT = CNT_W'(MUL_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LAT = CNT_W'(DIV_CYCLES);

    typedef enum logic {
        IDLE    = 1'b0,
        MD_BUSY = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PERF_W-1:0]  stall_cycles_q, stall_cycles_d;

    logic [CNT_W-1:0]   lat;
    logic               md_stall;
    logic               load_use;
    logic               flush_req;

    // MUL/DIV sequencing: the first EX cycle is handled in IDLE, so the counter
    // only has to cover the remaining LAT-1 cycles and ends on the done cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        md_stall = 1'b0;
        md_done  = 1'b0;
        lat      = md_is_div_ex ? DIV_LAT : MUL_LAT;
        case (state_q)
            IDLE: begin
                if (md_op_ex) begin
                    if (lat > CNT_W'(1)) begin
                        md_stall = 1'b1;
                        cnt_d    = lat - CNT_W'(2);
                        state_d  = MD_BUSY;
                    end else begin
                        md_done = 1'b1;
                    end
                end
            end
            MD_BUSY: begin
                if (cnt_q != '0) begin
                    md_stall = 1'b1;
                    cnt_d    = cnt_q - CNT_W'(1);
                end else begin
                    md_done = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // While a MUL/DIV holds EX the instruction there is not a branch, so a
    // taken indication is not acted on.
    always_comb begin
        md_busy   = (state_q == MD_BUSY);
        flush_req = branch_taken_ex & ~md_busy;
        load_use  = mem_read_ex & (rd_ex != '0) &
                    ((rs1_used_id & (rs1_id == rd_ex)) |
                     (rs2_used_id & (rs2_id == rd_ex)));

        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        id_ex_stall  = 1'b0;
        ex_stall     = 1'b0;

        if (md_stall) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_stall = 1'b1;
            ex_stall    = 1'b1;
        end else if (flush_req) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (load_use) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_bubble = 1'b1;
        end

        stall_cycles_d = stall_cycles_q + PERF_W'(pc_stall);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: two instances (default latencies, and single-cycle MUL
// with a 4-bit stall counter) share stimulus and are compared with an occupancy model.
module tb_hazard_ctrl_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1_id, rs2_id, rd_ex;
    logic       rs1_used_id, rs2_used_id, mem_read_ex, branch_taken_ex;
    logic       md_op_ex, md_is_div_ex;

    logic        pc_a, ifs_a, fl_a, bub_a, ids_a, exs_a, busy_a, done_a;
    logic        pc_b, ifs_b, fl_b, bub_b, ids_b, exs_b, busy_b, done_b;
    logic [31:0] sc_a;
    logic [3:0]  sc_b;
    logic [7:0]  outs_a, outs_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_ctrl_unit #(.REG_AW(5), .MUL_CYCLES(3), .DIV_CYCLES(33), .PERF_W(32)) dut_a (
        .clk(clk), .rst(rst), .rs1_id(rs1_id), .rs2_id(rs2_id),
        .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id), .rd_ex(rd_ex),
        .mem_read_ex(mem_read_ex), .branch_taken_ex(branch_taken_ex),
        .md_op_ex(md_op_ex), .md_is_div_ex(md_is_div_ex),
        .pc_stall(pc_a), .if_id_stall(ifs_a), .if_id_flush(fl_a), .id_ex_bubble(bub_a),
        .id_ex_stall(ids_a), .ex_stall(exs_a), .md_busy(busy_a), .md_done(done_a),
        .stall_cycles(sc_a));

    hazard_ctrl_unit #(.REG_AW(5), .MUL_CYCLES(1), .DIV_CYCLES(33), .PERF_W(4)) dut_b (
        .clk(clk), .rst(rst), .rs1_id(rs1_id), .rs2_id(rs2_id),
        .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id), .rd_ex(rd_ex),
        .mem_read_ex(mem_read_ex), .branch_taken_ex(branch_taken_ex),
        .md_op_ex(md_op_ex), .md_is_div_ex(md_is_div_ex),
        .pc_stall(pc_b), .if_id_stall(ifs_b), .if_id_flush(fl_b), .id_ex_bubble(bub_b),
        .id_ex_stall(ids_b), .ex_stall(exs_b), .md_busy(busy_b), .md_done(done_b),
        .stall_cycles(sc_b));

    assign outs_a = {pc_a, ifs_a, fl_a, bub_a, ids_a, exs_a, busy_a, done_a};
    assign outs_b = {pc_b, ifs_b, fl_b, bub_b, ids_b, exs_b, busy_b, done_b};

    // Reference: 'occ' is how many EX cycles the current MUL/DIV op has already spent.
    int          occ_a = 0, lat_a = 0, occ_b = 0, lat_b = 0;
    int          nocc_a, nlat_a, nocc_b, nlat_b;
    logic [7:0]  exp_a, exp_b;
    logic [31:0] mcnt_a = '0;
    logic [3:0]  mcnt_b = '0;

    function automatic void model(input int occ, input int cur_lat, input int mul_c,
                                  input int div_c, output logic [7:0] o,
                                  output int occ_n, output int lat_n);
        int   age, lat;
        logic stall, done, busy, br, lu;
        busy = (occ > 0);
        if (busy) begin
            age = occ + 1;
            lat = cur_lat;
        end else if (md_op_ex) begin
            age = 1;
            lat = md_is_div_ex ? div_c : mul_c;
        end else begin
            age = 0;
            lat = 0;
        end
        stall = (age > 0) && (age < lat);
        done  = (age > 0) && (age == lat);
        br    = branch_taken_ex && !busy;
        lu    = mem_read_ex && (rd_ex != 0) &&
                ((rs1_used_id && rs1_id == rd_ex) || (rs2_used_id && rs2_id == rd_ex));
        o[7] = stall || (!br && lu);
        o[6] = stall || (!br && lu);
        o[5] = !stall && br;
        o[4] = !stall && (br || lu);
        o[3] = stall;
        o[2] = stall;
        o[1] = busy;
        o[0] = done;
        occ_n = stall ? age : 0;
        lat_n = lat;
    endfunction

    always_comb begin
        model(occ_a, lat_a, 3, 33, exp_a, nocc_a, nlat_a);
        model(occ_b, lat_b, 1, 33, exp_b, nocc_b, nlat_b);
    end

    always @(posedge clk) begin
        if (rst) begin
            occ_a <= 0; lat_a <= 0; mcnt_a <= '0;
            occ_b <= 0; lat_b <= 0; mcnt_b <= '0;
        end else begin
            occ_a  <= nocc_a; lat_a <= nlat_a; mcnt_a <= mcnt_a + 32'(exp_a[7]);
            occ_b  <= nocc_b; lat_b <= nlat_b; mcnt_b <= mcnt_b + 4'(exp_b[7]);
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rs1_id = '0; rs2_id = '0; rd_ex = '0;
        rs1_used_id = 1'b0; rs2_used_id = 1'b0; mem_read_ex = 1'b0;
        branch_taken_ex = 1'b0; md_op_ex = 1'b0; md_is_div_ex = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        next_cycle();
        next_cycle();
        @(negedge clk);
        checks++;
        if (outs_a !== 8'h00 || outs_b !== 8'h00) begin
            errors++;
            $display("FAIL reset_outs got a=%b b=%b want 00000000", outs_a, outs_b);
        end
        checks++;
        if (sc_a !== 32'd0 || sc_b !== 4'd0) begin
            errors++;
            $display("FAIL reset_count got a=%0d b=%0d want 0", sc_a, sc_b);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_load_use_rs2();
        clear_inputs();
        mem_read_ex = 1'b1; rd_ex = 5'd7; rs2_id = 5'd7; rs2_used_id = 1'b1; rs1_id = 5'd3;
        @(negedge clk);
        checks++;
        if (outs_a !== 8'b1101_0000 || outs_a !== exp_a) begin
            errors++;
            $display("FAIL t1_outs got %b want %b", outs_a, 8'b1101_0000);
        end
        next_cycle();
        clear_inputs();
        @(negedge clk);
        checks++;
        if (sc_a !== 32'd1) begin
            errors++;
            $display("FAIL t1_count got %0d want 1", sc_a);
        end
        checks++;
        if (outs_a !== 8'h00) begin
            errors++;
            $display("FAIL t1_release got %b want 00000000", outs_a);
        end
        next_cycle();
    endtask

    task automatic test_x0_unused();
        clear_inputs();
        mem_read_ex = 1'b1; rd_ex = 5'd0; rs1_id = 5'd0; rs1_used_id = 1'b1;
        @(negedge clk);
        checks++;
        if (outs_a !== 8'h00) begin
            errors++;
            $display("FAIL t2_x0 got %b want 00000000", outs_a);
        end
        next_cycle();
        rd_ex = 5'd5; rs1_id = 5'd5; rs1_used_id = 1'b0;
        @(negedge clk);
        checks++;
        if (outs_a !== 8'h00) begin
            errors++;
            $display("FAIL t2_unused got %b want 00000000", outs_a);
        end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_branch_load_use();
        clear_inputs();
        mem_read_ex = 1'b1; rd_ex = 5'd7; rs2_id = 5'd7; rs2_used_id = 1'b1;
        branch_taken_ex = 1'b1;
        @(negedge clk);
        checks++;
        if (outs_a !== 8'b0011_0000 || outs_a !== exp_a) begin
            errors++;
            $display("FAIL t3_branch got %b want %b", outs_a, 8'b0011_0000);
        end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_div();
        int          ex_cnt = 0, done_cyc = 0, busy_bad = 0;
        logic [31:0] base;
        do_reset();
        base = mcnt_a;
        md_op_ex = 1'b1; md_is_div_ex = 1'b1;
        for (int c = 1; c <= 33; c++) begin
            @(negedge clk);
            checks++;
            if (outs_a !== exp_a) begin
                errors++;
                $display("FAIL t4_cycle%0d got %b want %b", c, outs_a, exp_a);
            end
            if (exs_a === 1'b1) ex_cnt++;
            if (done_a === 1'b1) done_cyc = c;
            if (busy_a !== ((c >= 2) ? 1'b1 : 1'b0)) busy_bad++;
            next_cycle();
        end
        clear_inputs();
        @(negedge clk);
        checks++;
        if (ex_cnt != 32 || done_cyc != 33 || busy_bad != 0) begin
            errors++;
            $display("FAIL t4_shape got ex=%0d done=%0d busybad=%0d want 32 33 0",
                     ex_cnt, done_cyc, busy_bad);
        end
        checks++;
        if (sc_a !== base + 32'd32) begin
            errors++;
            $display("FAIL t4_count got %0d want %0d", sc_a, base + 32'd32);
        end
        next_cycle();
    endtask

    task automatic test_mul_single();
        do_reset();
        md_op_ex = 1'b1; md_is_div_ex = 1'b0;
        @(negedge clk);
        checks++;
        if (outs_b !== 8'b0000_0001) begin
            errors++;
            $display("FAIL t5_done got %b want 00000001", outs_b);
        end
        checks++;
        if (outs_a !== exp_a) begin
            errors++;
            $display("FAIL t5_mul3 got %b want %b", outs_a, exp_a);
        end
        next_cycle();
        clear_inputs();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (outs_b !== 8'h00 || sc_b !== 4'd0 || outs_a !== exp_a) begin
                errors++;
                $display("FAIL t5_after%0d got a=%b b=%b cb=%0d want a=%b b=00000000 cb=0",
                         c, outs_a, outs_b, sc_b, exp_a);
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_mid_div_wrap();
        do_reset();
        md_op_ex = 1'b1; md_is_div_ex = 1'b1;
        for (int c = 1; c < 10; c++) next_cycle();
        clear_inputs();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (outs_a !== 8'h00 || outs_b !== 8'h00 || sc_a !== 32'd0 || sc_b !== 4'd0) begin
            errors++;
            $display("FAIL t6_abort got a=%b b=%b ca=%0d cb=%0d want all 0",
                     outs_a, outs_b, sc_a, sc_b);
        end
        mem_read_ex = 1'b1; rd_ex = 5'd9; rs1_id = 5'd9; rs1_used_id = 1'b1;
        for (int c = 0; c < 17; c++) next_cycle();
        clear_inputs();
        @(negedge clk);
        checks++;
        if (sc_b !== 4'd1) begin
            errors++;
            $display("FAIL t6_wrap got %0d want 1", sc_b);
        end
        checks++;
        if (sc_a !== 32'd17) begin
            errors++;
            $display("FAIL t6_count32 got %0d want 17", sc_a);
        end
        next_cycle();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            rs1_id          = 5'($urandom_range(0, 7));
            rs2_id          = 5'($urandom_range(0, 7));
            rd_ex           = 5'($urandom_range(0, 7));
            rs1_used_id     = 1'($urandom_range(0, 1));
            rs2_used_id     = 1'($urandom_range(0, 1));
            mem_read_ex     = 1'($urandom_range(0, 1));
            branch_taken_ex = ($urandom_range(0, 3) == 0);
            md_op_ex        = ($urandom_range(0, 9) == 0);
            md_is_div_ex    = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            checks++;
            if (outs_a !== exp_a) begin
                errors++;
                $display("FAIL rand_a%0d got %b want %b", c, outs_a, exp_a);
            end
            checks++;
            if (outs_b !== exp_b) begin
                errors++;
                $display("FAIL rand_b%0d got %b want %b", c, outs_b, exp_b);
            end
            checks++;
            if (sc_a !== mcnt_a || sc_b !== mcnt_b) begin
                errors++;
                $display("FAIL rand_cnt%0d got a=%0d b=%0d want a=%0d b=%0d",
                         c, sc_a, sc_b, mcnt_a, mcnt_b);
            end
            next_cycle();
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        #1;
        test_reset();
        test_load_use_rs2();
        test_x0_unused();
        test_branch_load_use();
        test_div();
        test_mul_single();
        test_reset_mid_div_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
